exe_mc: RTL and testbench
=========================

# exe_mc

Parametrised multi-cycle execute stage for the 16-bit MIPS-style pipeline. It sits between the ID/EX and EX/MEM registers. Single-cycle ALU ops (arithmetic, shift, logic, move) resolve combinationally. An iterative multiply/divide unit holds the pipeline through `stallreq_o` until its result is ready.

## Interface
- `WIDTH`, 16: datapath width; must be ≥4 and a power of two.
- `RADDR`, 4: register-address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush_i` in 1: aborts any in-flight mul/div.
- `aluop_i` in 3: op within class.
- `alusel_i` in 3: op class.
- `reg0_i` in WIDTH: operand A.
- `reg1_i` in WIDTH: operand B.
- `waddr_i` in RADDR: destination register.
- `we_i` in 1: write enable.
- `stallreq_o` out 1: stage needs more cycles; upstream must hold its inputs stable.
- `aluop_o` out 3: `aluop_i` passed through.
- `waddr_o` out RADDR: `waddr_i` passed through.
- `we_o` out 1: `we_i & ~stallreq_o`.
- `wdata_o` out WIDTH: result.

## Operation
- **ARITH (111)**
  - 000 add.
  - 001 sub (A−B).
  - 010 slt, signed.
  - 011 sltu.
  - slt/sltu return 1 or 0.
  - Results wrap modulo 2^WIDTH.
- **SHIFT (110)**
  - 000 sll.
  - 001 srl.
  - 010 sra.
  - Shift amount is `reg1_i[log2(WIDTH)-1:0]`; upper bits are ignored.
- **LOGIC (101)**: 000 and, 001 or, 010 xor, 011 not A.
- **MOVE (100)**: 000 pass A, 001 pass B.
- **MULDIV (010)**, all unsigned:
  - 000 product low WIDTH bits.
  - 001 product high WIDTH bits.
  - 010 quotient.
  - 011 remainder.
- **NOP (000)**, and any undefined sel/op combination: `wdata_o`=0. `we_o` still follows `we_i`.
- **Multiply**: iterative shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **Divide**: restoring, one quotient bit per cycle.
- **Divide by zero**: quotient = all ones, remainder = A. Same cycle count as a normal divide; no flag.
- **FSM** (in the sub-module):
  - IDLE → BUSY when `alusel_i`=MULDIV. Operands and op are latched and the counter is loaded with WIDTH−1.
  - BUSY → BUSY while counter ≠ 0; the counter decrements each cycle.
  - BUSY → DONE when counter = 0, after the final iteration.
  - DONE → IDLE unconditionally. In DONE, `wdata_o` is taken from the result register.
- **Flush**: `flush_i` in any state forces IDLE at the next edge and discards the partial result. While `flush_i` is high, `stallreq_o`=0. Flush has priority over starting a new op.
- **Reset**: `rst` high forces IDLE and clears the counter, operand registers and result register immediately, including mid-operation.

## Timing
- **Single-cycle classes**: zero latency. `stallreq_o`=0 throughout.
- **MULDIV issue**: the MULDIV op is first presented in cycle 0, with the FSM in IDLE.
- **`stallreq_o`**: combinational; high when `alusel_i`=MULDIV and state ≠ DONE and `flush_i`=0.
  - High in cycles 0 through WIDTH, i.e. WIDTH+1 cycles.
  - Cycle WIDTH+1 is DONE: `stallreq_o`=0, `wdata_o` is valid, `we_o`=`we_i`.
- **Back-to-back MULDIV**: cycle WIDTH+2 is IDLE again. If it sees a new MULDIV op, that op starts immediately; no extra bubble beyond the IDLE cycle.
- **Inputs during BUSY**: inputs must stay stable. Operands are latched at issue, so input changes do not corrupt the result.
- **While `rst`=1**: all outputs are 0, including `stallreq_o`, `we_o`, `wdata_o`, `waddr_o` and `aluop_o`.

## Structure
- **`exe_pkg`** holds:
  - alusel class constants: ARITH, SHIFT, LOGIC, MOVE, MULDIV, NOP.
  - aluop constants per class.
  - the `muldiv_state_t` enum: IDLE, BUSY, DONE.
- **`exe_muldiv`** sub-module:
  - Parametrised by WIDTH.
  - Contains the FSM, counter, accumulator/partial-remainder registers and result selection.
  - Outputs `busy` (state ≠ DONE while requested) and `result`.
- **Top level** contains the combinational single-cycle ALU, the class mux, the stall/`we` gating, and the pass-through fields.

## Test plan
All scenarios use WIDTH=16.
1. ARITH add, A=8, B=1, waddr=1, we=1 → `wdata_o`=9, `we_o`=1, `waddr_o`=1 in the same cycle, `stallreq_o`=0. Sub 1−8 → 0xFFF9. slt 0x8000 vs 1 → 1; sltu → 0.
2. SHIFT with A=0x807F:
   - sra by 4 → 0xF807.
   - srl by 4 → 0x0807.
   - sll by 4 → 0x07F0.
   - B=0x0014 masks to shift amount 4; same results.
3. MULDIV 300×300:
   - `stallreq_o` high for exactly 17 cycles, `we_o`=0 throughout.
   - Op 000 → 0x5F90; op 001 → 0x0001.
   - Then 0xFFFF×0xFFFF → low 0x0001, high 0xFFFE.
4. Divide:
   - 100/7 → quotient 14, remainder 2.
   - 5/0 → quotient 0xFFFF, remainder 5, in 17 stall cycles.
5. Abort:
   - `flush_i` pulsed in cycle 5 of a multiply → `stallreq_o` low that cycle; the next MULDIV restarts a full 17-cycle stall with a correct result.
   - `rst` asserted in cycle 8 → all outputs 0 immediately.
6. Back-to-back ops:
   - Two consecutive MULDIV ops, 6×7 then 9/2 → results 42 and 4, with one IDLE cycle between the stall windows.
   - Then an ARITH op → 0 stall cycles.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared constants and types for the multi-cycle execute stage.
package exe_pkg;

   // Operation classes (alusel)
   localparam logic [2:0] ALUSEL_NOP    = 3'b000;
   localparam logic [2:0] ALUSEL_MULDIV = 3'b010;
   localparam logic [2:0] ALUSEL_MOVE   = 3'b100;
   localparam logic [2:0] ALUSEL_LOGIC  = 3'b101;
   localparam logic [2:0] ALUSEL_SHIFT  = 3'b110;
   localparam logic [2:0] ALUSEL_ARITH  = 3'b111;

   // ARITH ops
   localparam logic [2:0] ALUOP_ADD  = 3'b000;
   localparam logic [2:0] ALUOP_SUB  = 3'b001;
   localparam logic [2:0] ALUOP_SLT  = 3'b010;
   localparam logic [2:0] ALUOP_SLTU = 3'b011;

   // SHIFT ops
   localparam logic [2:0] ALUOP_SLL = 3'b000;
   localparam logic [2:0] ALUOP_SRL = 3'b001;
   localparam logic [2:0] ALUOP_SRA = 3'b010;

   // LOGIC ops
   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_XOR = 3'b010;
   localparam logic [2:0] ALUOP_NOT = 3'b011;

   // MOVE ops
   localparam logic [2:0] ALUOP_MOVA = 3'b000;
   localparam logic [2:0] ALUOP_MOVB = 3'b001;

   // MULDIV ops: bit 1 picks divide, bit 0 picks the upper accumulator half
   localparam logic [2:0] ALUOP_MULLO = 3'b000;
   localparam logic [2:0] ALUOP_MULHI = 3'b001;
   localparam logic [2:0] ALUOP_DIVQ  = 3'b010;
   localparam logic [2:0] ALUOP_DIVR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/exe_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// A single 2*WIDTH accumulator serves both: {hi, lo} = {product hi, product lo}
// for multiply and {remainder, quotient} for divide, so op[0] always picks hi.
module exe_muldiv
   import exe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output muldiv_state_t        state_o,
   output logic [WIDTH-1:0]     result_o
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_t      state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_r;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_next;

   // One iteration of each algorithm from the current accumulator
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_r     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_r >= {1'b0, b_q});
      div_rem   = div_ge ? WIDTH'(div_r - {1'b0, b_q}) : div_r[WIDTH-1:0];
      div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
      step_next = op_q[1] ? div_next : mul_next;
   end

   // Next-state logic: issue, iterate, finish; flush wins over everything
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = BUSY;
               acc_d   = {{WIDTH{1'b0}}, a_i};
               b_d     = b_i;
               op_d    = op_i;
               cnt_d   = CW'(WIDTH - 1);
            end
         end
         BUSY: begin
            acc_d = step_next;
            if (cnt_q == '0) begin
               state_d  = DONE;
               // Undefined MULDIV ops (op[2] set) produce zero
               result_d = op_q[2] ? '0 :
                          (op_q[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0]);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = start_i && (state_q != DONE) && !flush_i;
   assign state_o  = state_q;
   assign result_o = result_q;

endmodule

// File: rtl/exe_mc.sv
// Multi-cycle execute stage: combinational single-cycle ALU plus an iterative
// mul/div unit that stalls the pipeline until its result is ready.
module exe_mc
   import exe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int RADDR = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [2:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [WIDTH-1:0]  reg0_i,
   input  logic [WIDTH-1:0]  reg1_i,
   input  logic [RADDR-1:0]  waddr_i,
   input  logic              we_i,
   output logic              stallreq_o,
   output logic [2:0]        aluop_o,
   output logic [RADDR-1:0]  waddr_o,
   output logic              we_o,
   output logic [WIDTH-1:0]  wdata_o
);

   localparam int SHW = $clog2(WIDTH);

   logic               md_busy;
   muldiv_state_t      md_state;
   logic [WIDTH-1:0]   md_result;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   alu_res;

   exe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .start_i  (alusel_i == ALUSEL_MULDIV),
      .op_i     (aluop_i),
      .a_i      (reg0_i),
      .b_i      (reg1_i),
      .busy_o   (md_busy),
      .state_o  (md_state),
      .result_o (md_result)
   );

   assign shamt = reg1_i[SHW-1:0];

   // Class/op mux; anything undefined yields zero
   always_comb begin
      alu_res = '0;
      case (alusel_i)
         ALUSEL_ARITH: begin
            case (aluop_i)
               ALUOP_ADD:  alu_res = reg0_i + reg1_i;
               ALUOP_SUB:  alu_res = reg0_i - reg1_i;
               ALUOP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(reg0_i) < $signed(reg1_i))};
               ALUOP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (reg0_i < reg1_i)};
               default:    alu_res = '0;
            endcase
         end
         ALUSEL_SHIFT: begin
            case (aluop_i)
               ALUOP_SLL: alu_res = reg0_i << shamt;
               ALUOP_SRL: alu_res = reg0_i >> shamt;
               ALUOP_SRA: alu_res = WIDTH'($signed(reg0_i) >>> shamt);
               default:   alu_res = '0;
            endcase
         end
         ALUSEL_LOGIC: begin
            case (aluop_i)
               ALUOP_AND: alu_res = reg0_i & reg1_i;
               ALUOP_OR:  alu_res = reg0_i | reg1_i;
               ALUOP_XOR: alu_res = reg0_i ^ reg1_i;
               ALUOP_NOT: alu_res = ~reg0_i;
               default:   alu_res = '0;
            endcase
         end
         ALUSEL_MOVE: begin
            case (aluop_i)
               ALUOP_MOVA: alu_res = reg0_i;
               ALUOP_MOVB: alu_res = reg1_i;
               default:    alu_res = '0;
            endcase
         end
         ALUSEL_MULDIV: alu_res = (md_state == DONE) ? md_result : '0;
         default:       alu_res = '0;
      endcase
   end

   // Output gating: everything reads zero while reset is held
   always_comb begin
      stallreq_o = !rst && md_busy;
      we_o       = !rst && we_i && !md_busy;
      wdata_o    = rst ? '0 : alu_res;
      waddr_o    = rst ? '0 : waddr_i;
      aluop_o    = rst ? '0 : aluop_i;
   end

endmodule

// File: tb/tb_exe_mc.sv
// Directed bench for exe_mc: driver issues ops and pushes expected writes,
// a negedge monitor pops and compares whenever the stage writes back.
module tb_exe_mc;
  import exe_pkg::*;

  localparam int W  = 16;
  localparam int RA = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush_i;
  logic [2:0]    aluop_i, alusel_i;
  logic [W-1:0]  reg0_i, reg1_i;
  logic [RA-1:0] waddr_i;
  logic          we_i;
  logic          stallreq_o;
  logic [2:0]    aluop_o;
  logic [RA-1:0] waddr_o;
  logic          we_o;
  logic [W-1:0]  wdata_o;

  exe_mc #(.WIDTH(W), .RADDR(RA)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg0_i     (reg0_i),
    .reg1_i     (reg1_i),
    .waddr_i    (waddr_i),
    .we_i       (we_i),
    .stallreq_o (stallreq_o),
    .aluop_o    (aluop_o),
    .waddr_o    (waddr_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o)
  );

  // Scoreboard
  logic [RA+W-1:0] exp_q[$];
  string           name_q[$];
  logic [RA+W-1:0] exp_item;
  string           exp_name;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write-back must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (stallreq_o) begin
        check("we_low_during_stall", 32'(we_o), 32'd0);
      end else if (we_o) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got wdata 0x%0h waddr %0d, expected no write", wdata_o, waddr_o);
        end else begin
          exp_item = exp_q.pop_front();
          exp_name = name_q.pop_front();
          check({exp_name, "_wdata"}, 32'(wdata_o), 32'(exp_item[W-1:0]));
          check({exp_name, "_waddr"}, 32'(waddr_o), 32'(exp_item[RA+W-1:W]));
        end
      end
    end
  end

  // Driver: issue one op, count its stall cycles, expect one write-back
  task automatic issue(input string name, input logic [2:0] sel, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [RA-1:0] wa,
                       input logic [W-1:0] exp, input int exp_stall);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({wa, exp});
    name_q.push_back(name);
    flush_i  = 1'b0;
    alusel_i = sel;
    aluop_i  = op;
    reg0_i   = a;
    reg1_i   = b;
    waddr_i  = wa;
    we_i     = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stallreq_o) n++;
      else done = 1'b1;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
  endtask

  task automatic go_idle(input int cycles);
    @(posedge clk); #1;
    flush_i  = 1'b0;
    alusel_i = ALUSEL_NOP;
    aluop_i  = 3'b000;
    we_i     = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stallreq"}, 32'(stallreq_o), 32'd0);
    check({tag, "_we"},       32'(we_o),       32'd0);
    check({tag, "_wdata"},    32'(wdata_o),    32'd0);
    check({tag, "_waddr"},    32'(waddr_o),    32'd0);
    check({tag, "_aluop"},    32'(aluop_o),    32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live-looking inputs: outputs must all read zero
    rst      = 1'b1;
    flush_i  = 1'b0;
    alusel_i = ALUSEL_ARITH;
    aluop_i  = ALUOP_SLTU;
    reg0_i   = 16'h0001;
    reg1_i   = 16'h0002;
    waddr_i  = 4'd5;
    we_i     = 1'b1;
    #12;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    alusel_i = ALUSEL_NOP;
    we_i     = 1'b0;

    // ARITH
    issue("add",  ALUSEL_ARITH, ALUOP_ADD,  16'h0008, 16'h0001, 4'd1, 16'h0009, 0);
    issue("sub",  ALUSEL_ARITH, ALUOP_SUB,  16'h0001, 16'h0008, 4'd2, 16'hFFF9, 0);
    issue("slt",  ALUSEL_ARITH, ALUOP_SLT,  16'h8000, 16'h0001, 4'd3, 16'h0001, 0);
    issue("sltu", ALUSEL_ARITH, ALUOP_SLTU, 16'h8000, 16'h0001, 4'd4, 16'h0000, 0);
    issue("add_wrap", ALUSEL_ARITH, ALUOP_ADD, 16'hFFFF, 16'h0002, 4'd5, 16'h0001, 0);

    // SHIFT, including upper shift-amount bits being ignored
    issue("sra",    ALUSEL_SHIFT, ALUOP_SRA, 16'h807F, 16'h0004, 4'd6, 16'hF807, 0);
    issue("srl",    ALUSEL_SHIFT, ALUOP_SRL, 16'h807F, 16'h0004, 4'd7, 16'h0807, 0);
    issue("sll",    ALUSEL_SHIFT, ALUOP_SLL, 16'h807F, 16'h0004, 4'd8, 16'h07F0, 0);
    issue("sra_m",  ALUSEL_SHIFT, ALUOP_SRA, 16'h807F, 16'h0014, 4'd9, 16'hF807, 0);
    issue("srl_m",  ALUSEL_SHIFT, ALUOP_SRL, 16'h807F, 16'h0014, 4'd10, 16'h0807, 0);
    issue("sll_m",  ALUSEL_SHIFT, ALUOP_SLL, 16'h807F, 16'h0014, 4'd11, 16'h07F0, 0);

    // LOGIC / MOVE / NOP / undefined
    issue("and",  ALUSEL_LOGIC, ALUOP_AND, 16'hF0F0, 16'hFF00, 4'd1, 16'hF000, 0);
    issue("or",   ALUSEL_LOGIC, ALUOP_OR,  16'hF0F0, 16'h0F0F, 4'd2, 16'hFFFF, 0);
    issue("xor",  ALUSEL_LOGIC, ALUOP_XOR, 16'hF0F0, 16'hFF00, 4'd3, 16'h0FF0, 0);
    issue("not",  ALUSEL_LOGIC, ALUOP_NOT, 16'hF0F0, 16'h1234, 4'd4, 16'h0F0F, 0);
    issue("mova", ALUSEL_MOVE,  ALUOP_MOVA, 16'hABCD, 16'h1234, 4'd5, 16'hABCD, 0);
    issue("movb", ALUSEL_MOVE,  ALUOP_MOVB, 16'hABCD, 16'h1234, 4'd6, 16'h1234, 0);
    issue("nop",  ALUSEL_NOP,   3'b000,     16'hABCD, 16'h1234, 4'd7, 16'h0000, 0);
    issue("arith_undef", ALUSEL_ARITH, 3'b111, 16'hABCD, 16'h1234, 4'd8, 16'h0000, 0);

    // MULDIV
    issue("mul300_lo", ALUSEL_MULDIV, ALUOP_MULLO, 16'd300, 16'd300, 4'd1, 16'h5F90, 17);
    issue("mul300_hi", ALUSEL_MULDIV, ALUOP_MULHI, 16'd300, 16'd300, 4'd2, 16'h0001, 17);
    issue("mulff_lo",  ALUSEL_MULDIV, ALUOP_MULLO, 16'hFFFF, 16'hFFFF, 4'd3, 16'h0001, 17);
    issue("mulff_hi",  ALUSEL_MULDIV, ALUOP_MULHI, 16'hFFFF, 16'hFFFF, 4'd4, 16'hFFFE, 17);
    issue("div_q",     ALUSEL_MULDIV, ALUOP_DIVQ, 16'd100, 16'd7, 4'd5, 16'd14, 17);
    issue("div_r",     ALUSEL_MULDIV, ALUOP_DIVR, 16'd100, 16'd7, 4'd6, 16'd2, 17);
    issue("div0_q",    ALUSEL_MULDIV, ALUOP_DIVQ, 16'd5, 16'd0, 4'd7, 16'hFFFF, 17);
    issue("div0_r",    ALUSEL_MULDIV, ALUOP_DIVR, 16'd5, 16'd0, 4'd8, 16'd5, 17);
    go_idle(2);

    // Flush in cycle 5 of a multiply, then a fresh multiply
    @(posedge clk); #1;
    alusel_i = ALUSEL_MULDIV;
    aluop_i  = ALUOP_MULLO;
    reg0_i   = 16'd300;
    reg1_i   = 16'd300;
    waddr_i  = 4'd9;
    we_i     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    flush_i = 1'b1;
    we_i    = 1'b0;
    @(negedge clk);
    check("flush_stallreq", 32'(stallreq_o), 32'd0);
    issue("after_flush", ALUSEL_MULDIV, ALUOP_MULLO, 16'd123, 16'd45, 4'd10, 16'h159F, 17);
    go_idle(2);

    // Reset in cycle 8 of a multiply
    @(posedge clk); #1;
    alusel_i = ALUSEL_MULDIV;
    aluop_i  = ALUOP_MULHI;
    reg0_i   = 16'd300;
    reg1_i   = 16'd300;
    waddr_i  = 4'd11;
    we_i     = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midop_reset");
    alusel_i = ALUSEL_NOP;
    we_i     = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back MULDIV, then a single-cycle op
    issue("b2b_mul", ALUSEL_MULDIV, ALUOP_MULLO, 16'd6, 16'd7, 4'd12, 16'd42, 17);
    issue("b2b_div", ALUSEL_MULDIV, ALUOP_DIVQ,  16'd9, 16'd2, 4'd13, 16'd4, 17);
    issue("b2b_add", ALUSEL_ARITH,  ALUOP_ADD,   16'd20, 16'd22, 4'd14, 16'd42, 0);

    go_idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
